// File: rtl/vga_scandoubler.sv
// Line-doubling scan converter: 15 kHz lines are captured into a ping-pong buffer and each is
// replayed twice at 31 kHz, with optional scanline dimming and a registered bypass path.
module vga_scandoubler #(
    parameter int unsigned LINE_MAX = 512,
    parameter int unsigned HS_LEN   = 54
) (
    input  logic       clk28,
    input  logic       rst,
    input  logic       en,
    input  logic       scanlines,
    input  logic       pix_stb,
    input  logic [1:0] r_i,
    input  logic [1:0] g_i,
    input  logic [1:0] b_i,
    input  logic       hsync_n_i,
    input  logic       vsync_n_i,
    output logic [1:0] r_o,
    output logic [1:0] g_o,
    output logic [1:0] b_o,
    output logic       hsync_n_o,
    output logic       vsync_n_o
);
    localparam int unsigned AW = $clog2(LINE_MAX);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] LineMax = LW'(LINE_MAX);
    localparam logic [LW-1:0] HsLen   = (HS_LEN > LINE_MAX) ? LineMax : LW'(HS_LEN);

    typedef enum logic [1:0] {StIdle, StPass0, StPass1} rd_state_e;

    logic [5:0]    line_mem [2*LINE_MAX];
    logic [5:0]    rd_data;
    logic          wr_bank;
    logic [LW-1:0] wr_x;          // counts up to LINE_MAX so a full line is distinguishable
    logic [LW-1:0] wr_x_inc;
    logic [LW-1:0] len_next;
    logic [AW-1:0] wr_addr;
    logic [LW-1:0] line_len;
    logic          hs_prev;
    logic          vs_lat;
    logic          en_q;
    logic          out_tgl;
    logic          boundary;
    rd_state_e     state_q, state_d;
    logic [AW-1:0] rd_x_q, rd_x_d;

    assign boundary = hs_prev & ~hsync_n_i;
    assign wr_addr  = wr_x[AW] ? AW'(LINE_MAX - 1) : wr_x[AW-1:0];
    assign wr_x_inc = wr_x[AW] ? wr_x : wr_x + LW'(1);
    assign len_next = pix_stb ? wr_x_inc : wr_x;

    // Buffer contents are not reset; the write address saturates so overflow rewrites the last slot.
    always_ff @(posedge clk28) begin
        if (pix_stb) begin
            line_mem[{wr_bank, wr_addr}] <= {r_i, g_i, b_i};
        end
        rd_data <= line_mem[{~wr_bank, rd_x_q}];
    end

    always_ff @(posedge clk28) begin
        if (rst) begin
            wr_bank  <= 1'b0;
            wr_x     <= '0;
            line_len <= '0;
            hs_prev  <= 1'b1;
            vs_lat   <= 1'b1;
            en_q     <= 1'b1;
        end else begin
            hs_prev <= hsync_n_i;
            if (boundary) begin
                line_len <= len_next;
                wr_x     <= '0;
                wr_bank  <= ~wr_bank;
                vs_lat   <= vsync_n_i;
                en_q     <= en;
            end else if (pix_stb) begin
                wr_x <= wr_x_inc;
            end
        end
    end

    always_ff @(posedge clk28) begin
        if (rst) begin
            state_q <= StIdle;
            rd_x_q  <= '0;
            out_tgl <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_x_q  <= rd_x_d;
            out_tgl <= boundary ? 1'b0 : ~out_tgl;
        end
    end

    always_comb begin
        state_d = state_q;
        rd_x_d  = rd_x_q;
        if (boundary) begin
            rd_x_d  = '0;
            state_d = (en && (len_next != '0)) ? StPass0 : StIdle;
        end else if (out_tgl && (state_q != StIdle)) begin
            if ({1'b0, rd_x_q} == line_len - LW'(1)) begin
                rd_x_d  = '0;
                state_d = (state_q == StPass0) ? StPass1 : StIdle;
            end else begin
                rd_x_d = rd_x_q + AW'(1);
            end
        end
    end

    // rd_data matches rd_x_q on every tick because the address only moves on ticks.
    always_ff @(posedge clk28) begin
        if (rst) begin
            r_o       <= '0;
            g_o       <= '0;
            b_o       <= '0;
            hsync_n_o <= 1'b1;
            vsync_n_o <= 1'b1;
        end else if (!en_q) begin
            r_o       <= r_i;
            g_o       <= g_i;
            b_o       <= b_i;
            hsync_n_o <= hsync_n_i;
            vsync_n_o <= vsync_n_i;
        end else begin
            if (boundary) begin
                vsync_n_o <= vs_lat;
            end
            if (out_tgl) begin
                if (state_q == StIdle) begin
                    r_o       <= '0;
                    g_o       <= '0;
                    b_o       <= '0;
                    hsync_n_o <= 1'b1;
                end else begin
                    hsync_n_o <= ({1'b0, rd_x_q} >= HsLen);
                    if ((state_q == StPass1) && scanlines) begin
                        r_o <= {1'b0, rd_data[5]};
                        g_o <= {1'b0, rd_data[3]};
                        b_o <= {1'b0, rd_data[1]};
                    end else begin
                        r_o <= rd_data[5:4];
                        g_o <= rd_data[3:2];
                        b_o <= rd_data[1:0];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_scandoubler.sv
// Directed bench for vga_scandoubler: drives whole input lines and checks the doubled output
// of the previous line against a small line-buffer model plus hand-computed spot values.
module tb_vga_scandoubler;
    logic       clk28 = 1'b0;
    logic       rst, en, scanlines, pix_stb;
    logic [1:0] r_i, g_i, b_i, r_o, g_o, b_o;
    logic       hsync_n_i, vsync_n_i, hsync_n_o, vsync_n_o;

    int n_checks = 0;
    int n_errors = 0;

    int cap_rgb [4096];
    int cap_hs  [4096];
    int cap_vs  [4096];

    logic [5:0] wr_buf   [512];
    logic [5:0] disp_buf [512];
    int         wr_cnt, disp_len;
    bit         lat_vs, disp_vs, prev_en;

    always #5 clk28 = ~clk28;

    vga_scandoubler dut (
        .clk28     (clk28),
        .rst       (rst),
        .en        (en),
        .scanlines (scanlines),
        .pix_stb   (pix_stb),
        .r_i       (r_i),
        .g_i       (g_i),
        .b_i       (b_i),
        .hsync_n_i (hsync_n_i),
        .vsync_n_i (vsync_n_i),
        .r_o       (r_o),
        .g_o       (g_o),
        .b_o       (b_o),
        .hsync_n_o (hsync_n_o),
        .vsync_n_o (vsync_n_o)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] pat_px(input int pat, input int k);
        case (pat)
            1:       return 6'h3F;
            2:       return (k == 599) ? 6'h2B : (k >= 512) ? 6'h2A : 6'(k % 64);
            default: return 6'(k % 64);
        endcase
    endfunction

    task automatic model_put(input logic [5:0] v);
        if (wr_cnt < 512) begin
            wr_buf[wr_cnt] = v;
            wr_cnt++;
        end else begin
            wr_buf[511] = v;
        end
    endtask

    // One input line: hsync falls at c=0, pixels every 4th clk28 from c=1, optional extra strobe at c=0.
    task automatic run_line(input string tag, input int npix, input int period, input int pat,
                            input int extra0, input bit vs, input bit sl, input bit en_v,
                            input int rst_at);
        int         bad, j, p, eh;
        logic [5:0] e, col;
        logic [7:0] prev_in;
        bit         stb, vs_chk;
        bad = 0;
        prev_in = '0;
        if (extra0 >= 0) model_put(6'(extra0));
        disp_buf = wr_buf;
        disp_len = wr_cnt;
        wr_cnt   = 0;
        disp_vs  = lat_vs;
        lat_vs   = vs;
        vs_chk   = prev_en;
        prev_en  = en_v;
        for (int c = 0; c < period; c++) begin
            @(negedge clk28);
            cap_rgb[c] = {r_o, g_o, b_o};
            cap_hs[c]  = hsync_n_o;
            cap_vs[c]  = vsync_n_o;
            if (rst_at < 0 || c <= rst_at) begin
                if (!en_v && c >= 2) begin
                    if ({hsync_n_o, vsync_n_o, r_o, g_o, b_o} != prev_in) bad++;
                end else if (en_v && c >= 3) begin
                    j = (c - 3) / 2;
                    if (j < 2 * disp_len) begin
                        p = j % disp_len;
                        e = disp_buf[p];
                        if (j >= disp_len && sl) e = {1'b0, e[5], 1'b0, e[3], 1'b0, e[1]};
                        eh = (p < 54) ? 0 : 1;
                    end else begin
                        e  = '0;
                        eh = 1;
                    end
                    if (cap_rgb[c] != int'(e) || cap_hs[c] != eh) bad++;
                    if (vs_chk && cap_vs[c] != int'(disp_vs)) bad++;
                end
            end
            rst       = (c == rst_at);
            en        = en_v;
            scanlines = sl;
            vsync_n_i = vs;
            hsync_n_i = (c < 8) ? 1'b0 : 1'b1;
            stb       = (c == 0 && extra0 >= 0) || (c % 4 == 1 && c / 4 < npix);
            if (c == 0 && extra0 >= 0) col = 6'(extra0);
            else if (stb)              col = pat_px(pat, c / 4);
            else                       col = 6'($urandom);
            pix_stb = stb;
            {r_i, g_i, b_i} = col;
            if (c == rst_at) begin
                wr_cnt  = 0;
                lat_vs  = 1'b1;
                prev_en = 1'b1;
            end
            if (stb && c > 0) model_put(col);
            prev_in = {hsync_n_i, vsync_n_i, col};
        end
        check_eq({tag, "_sweep"}, bad, 0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; scanlines = 1'b0; pix_stb = 1'b0;
        {r_i, g_i, b_i} = '0; hsync_n_i = 1'b1; vsync_n_i = 1'b1;
        wr_cnt = 0; disp_len = 0; lat_vs = 1'b1; disp_vs = 1'b1; prev_en = 1'b1;
        repeat (3) @(negedge clk28);
        check_eq("rst_rgb", {r_o, g_o, b_o}, 0);
        check_eq("rst_hs", hsync_n_o, 1);
        check_eq("rst_vs", vsync_n_o, 1);
        rst = 1'b0;
        repeat (4) @(negedge clk28);

        // First line after reset has nothing to replay.
        run_line("a", 448, 1792, 0, -1, 1'b1, 1'b0, 1'b1, -1);
        check_eq("a_idle_rgb", cap_rgb[100], 0);
        check_eq("a_idle_hs", cap_hs[100], 1);

        run_line("b", 448, 1792, 1, -1, 1'b0, 1'b0, 1'b1, -1);
        check_eq("b_px0", cap_rgb[3], 0);
        check_eq("b_hs_start", cap_hs[3], 0);
        check_eq("b_px5a", cap_rgb[13], 5);
        check_eq("b_px5b", cap_rgb[14], 5);
        check_eq("b_px63", cap_rgb[129], 63);
        check_eq("b_px64", cap_rgb[131], 0);
        check_eq("b_hs53", cap_hs[109], 0);
        check_eq("b_hs54", cap_hs[111], 1);
        check_eq("b_px447", cap_rgb[897], 63);
        check_eq("b_pass1_px0", cap_rgb[899], 0);
        check_eq("b_pass1_hs", cap_hs[899], 0);
        check_eq("b_vs", cap_vs[5], 1);

        run_line("c", 8, 1792, 0, -1, 1'b1, 1'b1, 1'b1, -1);
        check_eq("c_pass0", cap_rgb[3], 63);
        check_eq("c_pass1_dim", cap_rgb[899], 21);
        check_eq("c_vs", cap_vs[5], 0);

        run_line("d", 0, 200, 0, -1, 1'b1, 1'b0, 1'b1, -1);
        run_line("e", 0, 200, 0, -1, 1'b1, 1'b0, 1'b1, -1);
        check_eq("e_empty_rgb", cap_rgb[50], 0);
        check_eq("e_empty_hs", cap_hs[50], 1);

        run_line("f", 600, 2404, 2, -1, 1'b1, 1'b0, 1'b1, -1);
        run_line("g", 8, 2100, 0, -1, 1'b1, 1'b0, 1'b1, -1);
        check_eq("g_ent510", cap_rgb[1023], 62);
        check_eq("g_ent511", cap_rgb[1025], 43);
        check_eq("g_pass1_ent0", cap_rgb[1027], 0);
        check_eq("g_pass1_hs", cap_hs[1027], 0);
        check_eq("g_tail_hs", cap_hs[2051], 1);

        // Line g's last pixel arrives on the same clk28 as h's hsync fall.
        run_line("h", 4, 200, 0, 17, 1'b1, 1'b0, 1'b1, -1);
        check_eq("h_coinc_px", cap_rgb[19], 17);
        check_eq("h_coinc_px_p1", cap_rgb[37], 17);
        check_eq("h_after_hs", cap_hs[39], 1);
        run_line("i", 0, 200, 0, -1, 1'b1, 1'b0, 1'b1, -1);
        check_eq("i_newbank_px0", cap_rgb[3], 0);
        check_eq("i_newbank_px1", cap_rgb[5], 1);

        run_line("j", 4, 100, 0, -1, 1'b1, 1'b0, 1'b0, -1);
        check_eq("j_byp_hs_lo", cap_hs[2], 0);
        check_eq("j_byp_hs_hi", cap_hs[9], 1);
        run_line("k", 4, 100, 0, -1, 1'b0, 1'b0, 1'b0, -1);
        run_line("l", 100, 400, 0, -1, 1'b0, 1'b0, 1'b1, -1);
        check_eq("l_px2", cap_rgb[7], 2);

        run_line("m", 0, 100, 0, -1, 1'b1, 1'b0, 1'b1, 20);
        check_eq("m_pre_rgb", cap_rgb[20], 8);
        check_eq("m_pre_hs", cap_hs[20], 0);
        check_eq("m_pre_vs", cap_vs[20], 0);
        check_eq("m_rst_rgb", cap_rgb[21], 0);
        check_eq("m_rst_hs", cap_hs[21], 1);
        check_eq("m_rst_vs", cap_vs[21], 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
